// File: rtl/prog_loader.sv
// Boot-time instruction-memory loader: assembles a length-prefixed, XOR-checked
// byte stream into INST_W-bit words and writes them from address 0 upward.
module prog_loader #(
    parameter int ADDR_W         = 10,
    parameter int INST_W         = 41,
    parameter int BYTES_PER_WORD = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        byteIn,
    input  logic              byteValid,
    output logic              byteReady,
    output logic              imemWen,
    output logic [ADDR_W-1:0] imemAddr,
    output logic [INST_W-1:0] imemData,
    output logic              cpuHold,
    output logic              done,
    output logic              err
);

    localparam int BUF_W   = 8 * BYTES_PER_WORD;
    localparam int BIDX_W  = $clog2(BYTES_PER_WORD);
    localparam int TOP_LSB = INST_W - 8 * (BYTES_PER_WORD - 1);
    localparam logic [BIDX_W-1:0] LAST_BYTE = BIDX_W'(BYTES_PER_WORD - 1);

    typedef enum logic [2:0] {
        IDLE, LEN_LO, LEN_HI, DATA, WRITE, CHK, DONE, ERR
    } state_t;

    state_t            state, next_state;
    logic [ADDR_W:0]   word_idx;
    logic [BIDX_W-1:0] byte_idx;
    logic [15:0]       len;
    logic [7:0]        csum;
    logic [BUF_W-1:0]  word_buf;

    logic              xfer, last_byte, top_bad, len_big;
    logic [15:0]       len_full;
    logic [BUF_W-1:0]  word_full;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        xfer      = byteValid && byteReady;
        len_full  = {byteIn, len[7:0]};
        len_big   = 32'(len_full) > (32'd1 << ADDR_W);
        last_byte = (byte_idx == LAST_BYTE);
        // Bits of the last byte beyond INST_W must be zero.
        top_bad   = (byteIn >> TOP_LSB) != 8'd0;
        word_full = word_buf;
        word_full[8*(BYTES_PER_WORD-1) +: 8] = byteIn;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE, DONE, ERR: if (start) next_state = LEN_LO;
            LEN_LO:          if (xfer) next_state = LEN_HI;
            LEN_HI: if (xfer) begin
                if (len_big)              next_state = ERR;
                else if (len_full == '0)  next_state = CHK;
                else                      next_state = DATA;
            end
            DATA: if (xfer && last_byte) next_state = top_bad ? ERR : WRITE;
            WRITE: next_state = (32'(word_idx) + 32'd1 == 32'(len)) ? CHK : DATA;
            CHK:   if (xfer) next_state = (byteIn == csum) ? DONE : ERR;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        byteReady = 1'b0;
        imemWen   = 1'b0;
        cpuHold   = 1'b1;
        done      = 1'b0;
        err       = 1'b0;
        case (state)
            LEN_LO, LEN_HI, DATA, CHK: byteReady = 1'b1;
            WRITE: imemWen = 1'b1;
            DONE: begin
                done    = 1'b1;
                cpuHold = 1'b0;
            end
            ERR: err = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            word_idx <= '0;
            byte_idx <= '0;
            len      <= '0;
            csum     <= '0;
            word_buf <= '0;
            imemAddr <= '0;
            imemData <= '0;
        end else begin
            case (state)
                IDLE, DONE, ERR: if (start) begin
                    csum     <= '0;
                    word_idx <= '0;
                    byte_idx <= '0;
                end
                LEN_LO: if (xfer) begin
                    len[7:0] <= byteIn;
                    csum     <= csum ^ byteIn;
                end
                LEN_HI: if (xfer) begin
                    len[15:8] <= byteIn;
                    csum      <= csum ^ byteIn;
                end
                DATA: if (xfer) begin
                    csum <= csum ^ byteIn;
                    word_buf[8*int'(byte_idx) +: 8] <= byteIn;
                    if (last_byte) begin
                        byte_idx <= '0;
                        // Output registers only move for a word that will really be written.
                        if (!top_bad) begin
                            imemAddr <= word_idx[ADDR_W-1:0];
                            imemData <= word_full[INST_W-1:0];
                        end
                    end else begin
                        byte_idx <= byte_idx + 1'b1;
                    end
                end
                WRITE: word_idx <= word_idx + 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Boot-time instruction-memory writer. It is the write side of the processor's instruction ROM, which the core only reads.
- Accepts a byte stream over a valid/ready handshake, assembles 41-bit instruction words, and writes them sequentially into instruction memory starting at address 0.
- Holds the core halted (cpuHold) until a complete, checksum-verified program is loaded.

Parameters:
- ADDR_W, 10, instruction memory address width.
- INST_W, 41, instruction word width; must be 41..48.
- BYTES_PER_WORD, 6, bytes per instruction word, equal to ceil(INST_W/8).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle pulse; begins a load from IDLE, DONE or ERR.
- byteIn  input  8  stream data byte.
- byteValid  input  1  byteIn is valid.
- byteReady  output  1  loader can accept a byte this cycle.
- imemWen  output  1  instruction memory write enable, one-cycle pulse.
- imemAddr  output  ADDR_W  instruction memory write address.
- imemData  output  INST_W  instruction word to write.
- cpuHold  output  1  1 = core halted / held off instruction memory.
- done  output  1  load completed, checksum OK.
- err  output  1  load failed.

Behaviour:
- Reset (rst=0, asynchronous) forces, regardless of state:
  - state = IDLE
  - byteReady = 0, imemWen = 0, imemAddr = 0, imemData = 0
  - cpuHold = 1, done = 0, err = 0
  - internal word index, byte index, length and checksum all cleared
- Handshake: a byte transfers on a rising clk edge where byteValid && byteReady. byteIn is ignored at every other time.
- Frame format, in order:
  - LEN_LO byte, then LEN_HI byte: 16-bit word count N.
  - N words, each BYTES_PER_WORD bytes, little-endian.
  - One checksum byte.
- Checksum: XOR of every byte before it in the frame, length bytes included.
- States:
  - IDLE: byteReady = 0. start -> LEN_LO, clearing checksum, word index and byte index.
  - LEN_LO: byteReady = 1. On transfer, latch N[7:0] -> LEN_HI.
  - LEN_HI: byteReady = 1. On transfer, latch N[15:8], then:
    - N > 2^ADDR_W -> ERR
    - N == 0 -> CHK
    - otherwise -> DATA
  - DATA: byteReady = 1. Each transfer places byteIn at bits [8*k+7:8*k] of the word, k = byte index 0..BYTES_PER_WORD-1. After the last byte:
    - any bit of the last byte at or above position INST_W-8*(BYTES_PER_WORD-1) is 1 -> ERR, no write. For the defaults this means last-byte bits [7:1].
    - otherwise -> WRITE
  - WRITE: exactly one cycle, byteReady = 0.
    - imemWen = 1, imemAddr = word index, imemData = assembled word.
    - Then word index increments; word index == N -> CHK, otherwise -> DATA.
  - CHK: byteReady = 1. On transfer, byteIn == running XOR -> DONE, otherwise -> ERR.
  - DONE: done = 1, cpuHold = 0, byteReady = 0. start -> LEN_LO, with done cleared and cpuHold reasserted in the same edge.
  - ERR: err = 1, cpuHold = 1, byteReady = 0. start -> LEN_LO, with err cleared.
- start is ignored in LEN_LO, LEN_HI, DATA, WRITE and CHK.
- Latency: the write pulse occurs on the cycle immediately after the edge that accepted the word's last byte.
- Minimum word cost: BYTES_PER_WORD+1 cycles per word, i.e. 7 cycles with the defaults.
- imemAddr and imemData hold their last values outside WRITE; only imemWen is qualified.
- Partial writes before an error are not undone; cpuHold keeps the core off them.
- N == 2^ADDR_W is legal: the final write lands at the top address, and the word index needs ADDR_W+1 bits.
- Holes in byteValid (backpressure on the sender side) only stall the FSM and change nothing else.

Test Plan:
- Normal load:
  - Stimulus: start; bytes 01 00 AB 89 67 45 23 01 23.
  - Required: one imemWen pulse with imemAddr=0, imemData=41'h1_2345_6789_AB; then done=1, cpuHold=0, err=0.
- Empty program:
  - Stimulus: start; bytes 00 00 00.
  - Required: no imemWen; done=1.
- Length too large:
  - Stimulus: start; bytes 01 04 (N=1025).
  - Required: err=1 on the next cycle; byteReady=0; cpuHold=1.
- Illegal top bits:
  - Stimulus: as the normal load, but the 8th byte is 02.
  - Required: no imemWen; err=1.
- Bad checksum:
  - Stimulus: as the normal load, but the last byte is 24.
  - Required: exactly one write occurs, then err=1, cpuHold=1.
  - Follow-up: a new start plus the correct frame ends with done=1, err=0.
- Backpressure and reset:
  - Stimulus: normal load with byteValid low on alternate cycles.
  - Required: identical write and done result.
  - Stimulus: rst low during DATA.
  - Required: outputs are immediately at reset values; the following start reloads cleanly.
